// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single unified memory.
//   Port A (cpu_*) is the multi-cycle CPU, port B (dma_*) the DMA/boot-loader.
//   One access at a time: IDLE picks an owner and latches its request, ACCESS
//   holds mem_en for MEM_LAT cycles, DONE pulses the owner's ack for one cycle.
// Ports:
//   clk, rst (synchronous, active-low)
//   cpu_req/we/addr/wdata in, cpu_rdata/ack/stall out
//   dma_req/we/addr/wdata in, dma_rdata/ack out
//   mem_en/we/addr/wdata out, mem_rdata in (valid in the last ACCESS cycle)
//   grant (one-hot {dma, cpu}), state (debug view of the FSM)
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_dma_q, last_dma_d;
  logic [1:0]          grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                pick_dma;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dma_d  = last_dma_q;
    grant_d     = grant_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    // DMA wins when it is alone, or on a tie when the CPU had the last turn.
    pick_dma    = dma_req & (~cpu_req | ~last_dma_q);

    case (state_q)
      IDLE: begin
        if (cpu_req | dma_req) begin
          grant_d     = pick_dma ? 2'b10 : 2'b01;
          last_dma_d  = pick_dma;
          cnt_d       = 4'd0;
          we_d        = pick_dma ? dma_we    : cpu_we;
          mem_addr_d  = pick_dma ? dma_addr  : cpu_addr;
          mem_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          // Memory read data is only valid in this final ACCESS cycle.
          if (!we_q) begin
            if (grant_q[1]) dma_rdata_d = mem_rdata;
            else            cpu_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_dma_q  <= 1'b1;
      grant_q     <= 2'b00;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dma_q  <= last_dma_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes decode from the state register so reset clears them immediately.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign cpu_ack   = (state_q == DONE) & grant_q[0];
  assign dma_ack   = (state_q == DONE) & grant_q[1];
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign grant     = grant_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A transaction-level model
// (owner + start cycle of the access in flight) predicts every output each
// cycle; directed sequences add hand-computed expectations. A second instance
// built with MEM_LAT = 1 covers the short-latency configuration.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dma_ack, mem_en, mem_we;
  logic [1:0]  grant, state;

  logic        cpu_req1, dma_req1;
  logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        cpu_ack1, cpu_stall1, dma_ack1, mem_en1, mem_we1;
  logic [1:0]  grant1, state1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign mem_rdata  = memval(mem_addr);
  assign mem_rdata1 = memval(mem_addr1);

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .state(state)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req1), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
    .dma_req(dma_req1), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .grant(grant1), .state(state1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic        m_valid = 1'b0;
  logic        m_busy, m_own, m_we, m_last_dma;
  int          m_start;
  logic [31:0] m_addr, m_wdata, m_crd, m_drd;
  int          mk;
  logic [1:0]  e_state, e_grant;
  logic        e_en, e_cack, e_dack;

  initial begin
    forever begin
      @(negedge clk);
      mk = cyc - m_start;
      if (m_valid) begin
        e_state = 2'b00; e_grant = 2'b00; e_en = 1'b0; e_cack = 1'b0; e_dack = 1'b0;
        if (m_busy) begin
          e_grant = m_own ? 2'b10 : 2'b01;
          if (mk < LAT) begin
            e_state = 2'b01; e_en = 1'b1;
          end else begin
            e_state = 2'b10; e_cack = ~m_own; e_dack = m_own;
          end
        end
        check("m_state",     32'(state),     32'(e_state));
        check("m_grant",     32'(grant),     32'(e_grant));
        check("m_mem_en",    32'(mem_en),    32'(e_en));
        check("m_mem_we",    32'(mem_we),    32'(e_en & m_we));
        check("m_mem_addr",  mem_addr,       m_addr);
        check("m_mem_wdata", mem_wdata,      m_wdata);
        check("m_cpu_ack",   32'(cpu_ack),   32'(e_cack));
        check("m_dma_ack",   32'(dma_ack),   32'(e_dack));
        check("m_cpu_rdata", cpu_rdata,      m_crd);
        check("m_dma_rdata", dma_rdata,      m_drd);
        check("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cack));
      end
      if (!rst) begin
        m_valid = 1'b1; m_busy = 1'b0; m_own = 1'b0; m_we = 1'b0; m_last_dma = 1'b1;
        m_start = 0; m_addr = '0; m_wdata = '0; m_crd = '0; m_drd = '0;
      end else if (m_valid) begin
        if (m_busy) begin
          if (mk == LAT - 1 && !m_we) begin
            if (m_own) m_drd = memval(m_addr);
            else       m_crd = memval(m_addr);
          end
          if (mk == LAT) m_busy = 1'b0;
        end else if (cpu_req || dma_req) begin
          if (cpu_req && dma_req) m_own = !m_last_dma;
          else                    m_own = dma_req;
          m_busy     = 1'b1;
          m_start    = cyc + 1;
          m_we       = m_own ? dma_we    : cpu_we;
          m_addr     = m_own ? dma_addr  : cpu_addr;
          m_wdata    = m_own ? dma_wdata : cpu_wdata;
          m_last_dma = m_own;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int t0, budget, nacks, n, n_en;
  int ack_off[4];
  int ack_own[4];

  initial begin
    rst = 1'b0; cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = 32'h11; dma_addr = 32'h22; cpu_wdata = 32'h5555_AAAA; dma_wdata = 32'h0;
    cpu_req1 = 1'b0; dma_req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin ack_off[i] = -1; ack_own[i] = -1; end

    // Reset held for three edges with both requests high.
    for (int i = 0; i < 3; i++) begin
      cyc_start();
      if (i == 2) rst = 1'b1;
      sample();
      check("rst_state",   32'(state),   32'h0);
      check("rst_grant",   32'(grant),   32'h0);
      check("rst_mem_en",  32'(mem_en),  32'h0);
      check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
      check("rst_dma_ack", 32'(dma_ack), 32'h0);
    end
    t0 = cyc;

    // Both requests held continuously: alternate CPU, DMA, CPU, DMA.
    nacks = 0; budget = 0;
    while (nacks < 4 && budget < 30) begin
      cyc_start(); sample(); budget++;
      if (budget == 1) check("rst_first_grant", 32'(grant), 32'h1);
      if (cpu_ack) begin ack_off[nacks] = cyc - t0; ack_own[nacks] = 0; nacks++; end
      else if (dma_ack) begin ack_off[nacks] = cyc - t0; ack_own[nacks] = 1; nacks++; end
    end
    check("fair_nacks", 32'(nacks), 32'h4);
    check("fair_off0", 32'(ack_off[0]), 32'd3);
    check("fair_off1", 32'(ack_off[1]), 32'd7);
    check("fair_off2", 32'(ack_off[2]), 32'd11);
    check("fair_off3", 32'(ack_off[3]), 32'd15);
    check("fair_own0", 32'(ack_own[0]), 32'd0);
    check("fair_own1", 32'(ack_own[1]), 32'd1);
    check("fair_own2", 32'(ack_own[2]), 32'd0);
    check("fair_own3", 32'(ack_own[3]), 32'd1);
    cyc_start(); cpu_req = 1'b0; dma_req = 1'b0; sample();

    // CPU read of 0x40.
    cyc_start(); cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1; sample();
    check("rd_stall_t0", 32'(cpu_stall), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc_start(); sample();
      if (k < 3) begin
        check("rd_mem_en",   32'(mem_en),    32'h1);
        check("rd_mem_addr", mem_addr,       32'h40);
        check("rd_stall",    32'(cpu_stall), 32'h1);
        check("rd_no_ack",   32'(cpu_ack),   32'h0);
      end else begin
        check("rd_ack",      32'(cpu_ack),   32'h1);
        check("rd_rdata",    cpu_rdata,      32'hDEADBEEF);
        check("rd_stall_ack", 32'(cpu_stall), 32'h0);
        check("rd_en_done",  32'(mem_en),    32'h0);
      end
    end
    cyc_start(); cpu_req = 1'b0; sample();

    // DMA write; inputs disturbed during ACCESS must not reach memory.
    cyc_start(); dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h12345678; dma_req = 1'b1; sample();
    for (int k = 1; k <= 3; k++) begin
      cyc_start();
      if (k == 1) begin dma_wdata = 32'hBAD0BAD0; dma_addr = 32'h999; end
      sample();
      if (k < 3) begin
        check("wr_mem_we",    32'(mem_we), 32'h1);
        check("wr_mem_addr",  mem_addr,    32'h100);
        check("wr_mem_wdata", mem_wdata,   32'h12345678);
      end else begin
        check("wr_ack",       32'(dma_ack), 32'h1);
        check("wr_rdata_keep", dma_rdata,   32'hA5A50022);
        check("wr_we_done",   32'(mem_we),  32'h0);
      end
    end
    cyc_start(); dma_req = 1'b0; dma_we = 1'b0; sample();

    // Reset on the second ACCESS cycle of a CPU read, then the request completes.
    cyc_start(); cpu_we = 1'b0; cpu_addr = 32'h80; cpu_req = 1'b1; sample();
    cyc_start(); sample();
    check("mid_access1", 32'(state), 32'h1);
    cyc_start(); rst = 1'b0; sample();
    check("mid_access2", 32'(mem_en), 32'h1);
    cyc_start(); rst = 1'b1; sample();
    check("mid_state",  32'(state),   32'h0);
    check("mid_no_ack", 32'(cpu_ack), 32'h0);
    check("mid_mem_en", 32'(mem_en),  32'h0);
    check("mid_rdata",  cpu_rdata,    32'h0);
    n = 0; budget = 0;
    while (budget < 10) begin
      cyc_start(); sample(); budget++;
      if (cpu_ack) begin n = budget; break; end
    end
    check("mid_reissue_lat", 32'(n), 32'd3);
    check("mid_reissue_rdata", cpu_rdata, 32'hA5A50080);
    cyc_start(); cpu_req = 1'b0; sample();

    // MEM_LAT = 1 instance: single CPU read.
    cyc_start(); cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req1 = 1'b1; sample();
    check("l1_stall_t0", 32'(cpu_stall1), 32'h1);
    n_en = 0;
    for (int k = 1; k <= 2; k++) begin
      cyc_start(); sample();
      if (mem_en1) n_en++;
      if (k == 1) begin
        check("l1_state_acc", 32'(state1),   32'h1);
        check("l1_grant",     32'(grant1),   32'h1);
        check("l1_addr",      mem_addr1,     32'h40);
        check("l1_wdata",     mem_wdata1,    32'h5555_AAAA);
        check("l1_we",        32'(mem_we1),  32'h0);
        check("l1_no_ack",    32'(cpu_ack1), 32'h0);
      end else begin
        check("l1_ack",       32'(cpu_ack1),   32'h1);
        check("l1_rdata",     cpu_rdata1,      32'hDEADBEEF);
        check("l1_state_done", 32'(state1),    32'h2);
        check("l1_stall_ack", 32'(cpu_stall1), 32'h0);
        check("l1_dma_ack",   32'(dma_ack1),   32'h0);
        check("l1_dma_rdata", dma_rdata1,      32'h0);
      end
    end
    check("l1_en_cycles", 32'(n_en), 32'h1);
    cyc_start(); cpu_req1 = 1'b0; sample();
    check("l1_idle", 32'(state1), 32'h0);
    cyc_start(); sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
